// File: rtl/alu_sequencer.sv
// Sequencer for an external 8-bit combinational ALU with a 4x8 register file.
// Runs one instruction every three cycles: issue (IDLE), settle/capture (EXEC), writeback (WB).
module alu_sequencer #(
  parameter int NREG = 4,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr,
  output logic [3:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_z,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic [1:0]   res_rd,
  output logic         res_zero,
  output logic         res_illegal,
  input  logic [1:0]   dbg_sel,
  output logic [W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDI = 4'b1111;

  state_t       state_q, state_d;
  logic [W-1:0] rf [NREG];
  logic [3:0]   op_p0;
  logic [1:0]   rd_p0;
  logic         ill_p0;
  logic         accept;

  logic [3:0]   instr_op;
  logic [1:0]   instr_rd;
  logic [1:0]   instr_rs;
  logic [7:0]   instr_imm;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'b1010) && (op <= 4'b1110);
  endfunction

  function automatic logic is_zero(input logic [W-1:0] v);
    return (v == '0);
  endfunction

  assign instr_op    = instr[15:12];
  assign instr_rd    = instr[11:10];
  assign instr_rs    = instr[9:8];
  assign instr_imm   = instr[7:0];
  assign instr_ready = (state_q == S_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign dbg_data    = rf[dbg_sel];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_p0       <= '0;
      rd_p0       <= '0;
      ill_p0      <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_rd      <= '0;
      res_zero    <= 1'b0;
      res_illegal <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      state_q   <= state_d;
      res_valid <= (state_q == S_EXEC);

      // Issue stage: operands read from the register file as it stands at the accept edge
      if (accept) begin
        op_p0  <= instr_op;
        rd_p0  <= instr_rd;
        ill_p0 <= is_illegal(instr_op);
        alu_op <= instr_op;
        alu_a  <= rf[instr_rd];
        alu_b  <= (instr_op == OP_LDI) ? instr_imm : rf[instr_rs];
      end

      // Capture stage: ALU has settled on the registered operands
      if (state_q == S_EXEC) begin
        res_data    <= ill_p0 ? '0 : alu_z;
        res_rd      <= rd_p0;
        res_zero    <= ill_p0 ? 1'b1 : is_zero(alu_z);
        res_illegal <= ill_p0;
      end

      // Writeback stage: result lands before the next instruction can be accepted
      if (state_q == S_WB) begin
        rf[res_rd] <= res_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model on the alu_* ports.
// Opcodes used: 0 add, 1 sub, 8 eq, 9 gt (unsigned), A..E illegal (0), F pass B.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_z;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [1:0]  res_rd;
  logic        res_zero;
  logic        res_illegal;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int total = 0;
  int passes = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.NREG(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .res_zero(res_zero), .res_illegal(res_illegal),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always_comb begin
    alu_z = 8'h00;
    case (alu_op)
      4'h0: alu_z = alu_a + alu_b;
      4'h1: alu_z = alu_a - alu_b;
      4'h8: alu_z = (alu_a == alu_b) ? 8'h01 : 8'h00;
      4'h9: alu_z = (alu_a > alu_b) ? 8'h01 : 8'h00;
      4'hF: alu_z = alu_b;
      default: alu_z = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic dbg_chk(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    dbg_sel = sel;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Called just after a rising edge with the sequencer idle; returns just after the edge ending WB.
  task automatic issue(input string tag, input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [7:0] imm, input logic [7:0] exp_data,
                       input logic exp_ill);
    int n;
    instr       = {op, rd, rs, imm};
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_ready"}, {7'd0, instr_ready}, 8'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk({tag, "_exec_novalid"}, {7'd0, res_valid}, 8'd0);
    @(posedge clk); #1;
    chk({tag, "_res_valid"}, {7'd0, res_valid}, 8'd1);
    chk({tag, "_res_data"}, res_data, exp_data);
    chk({tag, "_res_rd"}, {6'd0, res_rd}, {6'd0, rd});
    chk({tag, "_res_zero"}, {7'd0, res_zero}, {7'd0, (exp_data == 8'h00)});
    chk({tag, "_res_illegal"}, {7'd0, res_illegal}, {7'd0, exp_ill});
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, {7'd0, res_valid}, 8'd0);
    dbg_chk({tag, "_dbg"}, rd, exp_data);
  endtask

  initial begin
    int rdy_cnt;
    int vld_cnt;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dbg_sel     = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {7'd0, instr_ready}, 8'd1);
    chk("rst_res_valid", {7'd0, res_valid}, 8'd0);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_op", {4'd0, alu_op}, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // load constant; new value visible on dbg the cycle after res_valid
    issue("ldi_r1", 4'hF, 2'd1, 2'd0, 8'h2A, 8'h2A, 1'b0);

    // reset during EXEC abandons the instruction and clears the register file
    issue("ldi_r0", 4'hF, 2'd0, 2'd0, 8'h55, 8'h55, 1'b0);
    instr       = {4'h0, 2'd1, 2'd0, 8'h00};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {7'd0, instr_ready}, 8'd1);
    chk("midrst_res_valid", {7'd0, res_valid}, 8'd0);
    chk("midrst_alu_a", alu_a, 8'h00);
    dbg_chk("midrst_r0", 2'd0, 8'h00);
    dbg_chk("midrst_r1", 2'd1, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("postrst_no_valid", {7'd0, res_valid}, 8'd0);
    end
    dbg_chk("postrst_r1", 2'd1, 8'h00);

    // add with wraparound, then rd==rs doubling
    issue("ldi_r1_f0", 4'hF, 2'd1, 2'd0, 8'hF0, 8'hF0, 1'b0);
    issue("ldi_r2_20", 4'hF, 2'd2, 2'd0, 8'h20, 8'h20, 1'b0);
    issue("add_r1_r2", 4'h0, 2'd1, 2'd2, 8'h00, 8'h10, 1'b0);
    issue("add_r1_r1", 4'h0, 2'd1, 2'd1, 8'h00, 8'h20, 1'b0);
    issue("ldi_r2_03", 4'hF, 2'd2, 2'd0, 8'h03, 8'h03, 1'b0);
    issue("sub_r2_r1", 4'h1, 2'd2, 2'd1, 8'h00, 8'hE3, 1'b0);

    // compare results and zero flag
    issue("ldi_r0_5", 4'hF, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0);
    issue("ldi_r3_5", 4'hF, 2'd3, 2'd0, 8'h05, 8'h05, 1'b0);
    issue("eq_r0_r3", 4'h8, 2'd0, 2'd3, 8'h00, 8'h01, 1'b0);
    issue("ldi_r0_5b", 4'hF, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0);
    issue("gt_r0_r3", 4'h9, 2'd0, 2'd3, 8'h00, 8'h00, 1'b0);

    // illegal op clears the destination and flags it
    issue("ldi_r2_77", 4'hF, 2'd2, 2'd0, 8'h77, 8'h77, 1'b0);
    issue("ill_c_r2", 4'hC, 2'd2, 2'd0, 8'h00, 8'h00, 1'b1);
    dbg_chk("after_ill_r3", 2'd3, 8'h05);

    // instr_valid held high: one accept and one writeback per 3 cycles
    instr       = {4'hF, 2'd3, 2'd0, 8'h3C};
    instr_valid = 1'b1;
    rdy_cnt = 0;
    vld_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (instr_ready) rdy_cnt++;
      if (res_valid) vld_cnt++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    chk("hs_ready_count", rdy_cnt[7:0], 8'd4);
    chk("hs_valid_count", vld_cnt[7:0], 8'd4);
    dbg_chk("hs_r3", 2'd3, 8'h3C);
    repeat (3) @(posedge clk);
    #1;
    chk("hs_idle_no_valid", {7'd0, res_valid}, 8'd0);
    chk("hs_idle_alu_op", {4'd0, alu_op}, 8'h0F);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
